// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage plus the IF/ID pipeline register of the five-stage
// MIPS pipeline. Owns the fetch PC, issues word requests to a variable-latency
// instruction memory (ready handshake) and presents instruction, PC and PC+4
// to decode. Branches/jumps resolve in decode with one delay slot. A resolved
// redirect that cannot be applied immediately is parked until the delay-slot
// fetch completes. A word fetched while decode is stalled is parked in a
// one-entry skid buffer.
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   imem_req       fetch request valid (combinational from reset/ibuf_valid)
//   imem_addr      word address of the outstanding request (bits[1:0] = 00)
//   imem_rdata     instruction word, valid when imem_ready = 1
//   imem_ready     completes the outstanding request this cycle
//   stall_D        hazard unit: hold the decode register
//   redirect_D     taken branch/jump currently in decode
//   redirect_sel   0: target from npc_target, 1: target from jr_target
//   npc_target     branch/jump target computed in decode
//   jr_target      forwarded rs value for jr/jalr
//   instr_D        decode instruction, 0 (nop) when bubble
//   PC_D, PC4_D    PC of instr_D and PC_D + 4
//   valid_D        instr_D is a real instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall_D,
  input  logic        redirect_D,
  input  logic        redirect_sel,
  input  logic [31:0] npc_target,
  input  logic [31:0] jr_target,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC4_D,
  output logic        valid_D
);

  // Fetch PC and pending redirect
  logic [31:0] pc_f;
  logic [31:0] redir_pc;
  logic        redir_valid;

  // One-entry skid buffer for a word that completed while decode was stalled
  logic [31:0] ibuf_instr;
  logic [31:0] ibuf_pc;
  logic [31:0] ibuf_pc4;
  logic        ibuf_valid;

  // Combinational helpers
  logic [31:0] raw_target;
  logic [31:0] target;
  logic [31:0] pc_f_plus4;
  logic        fetch_done;
  logic        redirect_taken;

  // The request is withheld only while the skid buffer is occupied, so the
  // buffer can never be overrun. The address is the fetch PC register, which
  // only moves on completion, keeping a waiting request stable.
  assign imem_req  = !reset && !ibuf_valid;
  assign imem_addr = pc_f;

  // Target selection; jr/jalr sources may carry misaligned low bits.
  always_comb begin
    raw_target     = redirect_sel ? jr_target : npc_target;
    target         = raw_target & 32'hFFFF_FFFC;
    pc_f_plus4     = pc_f + 32'd4;
    fetch_done     = imem_req && imem_ready;
    redirect_taken = redirect_D && valid_D && !stall_D;
  end

  // Fetch PC and pending-redirect register.
  // A parked redirect always wins on the next completion, because that
  // completion is the delay slot. When no fetch completes alongside an
  // honoured redirect there are two cases: if the delay slot already sits in
  // the skid buffer, nothing is outstanding and the PC can jump at once;
  // otherwise the delay slot is still in flight and the target is parked.
  // A second redirect while one is parked keeps the first.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f        <= RESET_PC;
      redir_pc    <= 32'd0;
      redir_valid <= 1'b0;
    end else if (fetch_done) begin
      if (redir_valid) begin
        pc_f        <= redir_pc;
        redir_valid <= 1'b0;
      end else if (redirect_taken) begin
        pc_f <= target;
      end else begin
        pc_f <= pc_f_plus4;
      end
    end else if (redirect_taken && !redir_valid) begin
      if (ibuf_valid) begin
        pc_f <= target;
      end else begin
        redir_pc    <= target;
        redir_valid <= 1'b1;
      end
    end
  end

  // Skid buffer: captures a completing fetch when decode cannot accept it and
  // empties as soon as decode is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      ibuf_instr <= 32'd0;
      ibuf_pc    <= 32'd0;
      ibuf_pc4   <= 32'd0;
      ibuf_valid <= 1'b0;
    end else if (fetch_done && stall_D) begin
      ibuf_instr <= imem_rdata;
      ibuf_pc    <= pc_f;
      ibuf_pc4   <= pc_f_plus4;
      ibuf_valid <= 1'b1;
    end else if (!stall_D) begin
      ibuf_valid <= 1'b0;
    end
  end

  // IF/ID register. The buffered word is older than anything in flight, so it
  // has priority; no request is issued while it is occupied, so the two
  // sources never compete. Bubbles zero the instruction but keep the PCs.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_D <= 32'd0;
      PC_D    <= 32'd0;
      PC4_D   <= 32'd0;
      valid_D <= 1'b0;
    end else if (!stall_D) begin
      if (ibuf_valid) begin
        instr_D <= ibuf_instr;
        PC_D    <= ibuf_pc;
        PC4_D   <= ibuf_pc4;
        valid_D <= 1'b1;
      end else if (fetch_done) begin
        instr_D <= imem_rdata;
        PC_D    <= pc_f;
        PC4_D   <= pc_f_plus4;
        valid_D <= 1'b1;
      end else begin
        instr_D <= 32'd0;
        valid_D <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// Self-checking bench for fetch_stage. The memory returns a word derived from
// its address, so every decoded instruction identifies where it came from.
// The reference model tracks the architectural decode stream (program order
// with one delay slot after each taken redirect) and the skid-buffer
// occupancy, and is checked after every clock edge.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall_D;
  logic        redirect_D;
  logic        redirect_sel;
  logic [31:0] npc_target;
  logic [31:0] jr_target;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC4_D;
  logic        valid_D;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .stall_D      (stall_D),
    .redirect_D   (redirect_D),
    .redirect_sel (redirect_sel),
    .npc_target   (npc_target),
    .jr_target    (jr_target),
    .instr_D      (instr_D),
    .PC_D         (PC_D),
    .PC4_D        (PC4_D),
    .valid_D      (valid_D)
  );

  always #5 clk = ~clk;

  // Address-derived instruction contents; never zero for an aligned address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic stall, input logic rd,
                               input logic sel, input logic [31:0] npc,
                               input logic [31:0] jr, input logic ready);
    @(negedge clk);
    reset        = rst;
    stall_D      = stall;
    redirect_D   = rd;
    redirect_sel = sel;
    npc_target   = npc;
    jr_target    = jr;
    imem_ready   = ready;
  endtask

  task automatic settle_edge();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [31:0] exp_pc      = RESET_PC;
  logic [31:0] pend_target = 32'd0;
  logic        ds_next     = 1'b0;
  logic        ds_in       = 1'b0;
  logic        buffered    = 1'b0;

  // Pre-edge snapshot
  logic        p_reset, p_stall, p_rd, p_req, p_ready, p_valid;
  logic [31:0] p_target, p_addr, p_pc, p_pc4, p_instr;

  initial begin : compare
    forever begin
      @(negedge clk);
      #2;
      p_reset  = reset;
      p_stall  = stall_D;
      p_rd     = redirect_D;
      p_req    = imem_req;
      p_ready  = imem_ready;
      p_valid  = valid_D;
      p_target = (redirect_sel ? jr_target : npc_target) & 32'hFFFF_FFFC;
      p_addr   = imem_addr;
      p_pc     = PC_D;
      p_pc4    = PC4_D;
      p_instr  = instr_D;
      @(posedge clk);
      #1;
      if (p_reset) begin
        checkOutput("reset_valid_D", valid_D, 32'd0);
        checkOutput("reset_instr_D", instr_D, 32'd0);
        checkOutput("reset_PC_D", PC_D, 32'd0);
        checkOutput("reset_PC4_D", PC4_D, 32'd0);
        checkOutput("reset_imem_addr", imem_addr, RESET_PC);
        exp_pc   = RESET_PC;
        ds_next  = 1'b0;
        ds_in    = 1'b0;
        buffered = 1'b0;
      end else begin
        if (p_rd && p_valid && !p_stall) begin
          ds_next     = 1'b1;
          pend_target = p_target;
        end
        if (p_stall) begin
          checkOutput("stall_hold_valid", valid_D, p_valid);
          checkOutput("stall_hold_instr", instr_D, p_instr);
          checkOutput("stall_hold_pc", PC_D, p_pc);
          checkOutput("stall_hold_pc4", PC4_D, p_pc4);
          if (p_req && p_ready) buffered = 1'b1;
        end else if (buffered || (p_req && p_ready)) begin
          checkOutput("dec_valid", valid_D, 32'd1);
          checkOutput("dec_pc", PC_D, exp_pc);
          checkOutput("dec_instr", instr_D, mem_word(exp_pc));
          checkOutput("dec_pc4", PC4_D, exp_pc + 32'd4);
          if (ds_next) begin
            exp_pc  = pend_target;
            ds_next = 1'b0;
            ds_in   = 1'b1;
          end else begin
            exp_pc = exp_pc + 32'd4;
            ds_in  = 1'b0;
          end
          buffered = 1'b0;
        end else begin
          checkOutput("bubble_valid", valid_D, 32'd0);
          checkOutput("bubble_instr", instr_D, 32'd0);
          checkOutput("bubble_pc_hold", PC_D, p_pc);
          checkOutput("bubble_pc4_hold", PC4_D, p_pc4);
        end
        if (p_req && !p_ready) begin
          checkOutput("wait_req_hold", imem_req, 32'd1);
          checkOutput("wait_addr_hold", imem_addr, p_addr);
        end
      end
      checkOutput("imem_req", imem_req, !reset && !buffered);
      checkOutput("addr_align", imem_addr[1:0], 32'd0);
    end
  end

  // Random stimulus storage
  logic        r_rst, r_stall, r_rd, r_sel, r_rdy;
  logic [31:0] r_npc, r_jr;

  initial begin : stimulus
    reset        = 1'b1;
    stall_D      = 1'b0;
    redirect_D   = 1'b0;
    redirect_sel = 1'b0;
    npc_target   = 32'd0;
    jr_target    = 32'd0;
    imem_ready   = 1'b1;

    // Reset state and sequential zero-wait fetch
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0, 1);
    settle_edge();
    checkOutput("T1_req_in_reset", imem_req, 32'd0);
    checkOutput("T1_valid_in_reset", valid_D, 32'd0);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1);
    #1;
    checkOutput("T1_first_req", imem_req, 32'd1);
    checkOutput("T1_first_addr", imem_addr, 32'h0000_3000);
    for (int i = 0; i < 3; i++) begin
      settle_edge();
      checkOutput("T1_seq_pc", PC_D, 32'h0000_3000 + 32'(i * 4));
      checkOutput("T1_seq_pc4", PC4_D, 32'h0000_3004 + 32'(i * 4));
      checkOutput("T1_seq_valid", valid_D, 32'd1);
    end

    // Taken branch, zero-wait: no bubbles
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0, 1);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1);
    settle_edge();
    checkOutput("T2_branch_pc", PC_D, 32'h0000_3000);
    applyStimulus(0, 0, 1, 0, 32'h0000_3040, 32'd0, 1);
    settle_edge();
    checkOutput("T2_slot_pc", PC_D, 32'h0000_3004);
    checkOutput("T2_slot_valid", valid_D, 32'd1);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1);
    settle_edge();
    checkOutput("T2_target_pc", PC_D, 32'h0000_3040);
    checkOutput("T2_target_valid", valid_D, 32'd1);
    settle_edge();
    checkOutput("T2_target4_pc", PC_D, 32'h0000_3044);

    // Same branch, delay-slot fetch waits 3 cycles
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0, 1);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1);
    settle_edge();
    applyStimulus(0, 0, 1, 0, 32'h0000_3040, 32'd0, 0);
    settle_edge();
    checkOutput("T3_wait_addr", imem_addr, 32'h0000_3004);
    checkOutput("T3_bubble", valid_D, 32'd0);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 0);
    settle_edge();
    checkOutput("T3_wait_addr2", imem_addr, 32'h0000_3004);
    settle_edge();
    checkOutput("T3_bubble3", valid_D, 32'd0);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1);
    settle_edge();
    checkOutput("T3_slot_pc", PC_D, 32'h0000_3004);
    checkOutput("T3_next_addr", imem_addr, 32'h0000_3040);
    settle_edge();
    checkOutput("T3_target_pc", PC_D, 32'h0000_3040);

    // jr with misaligned source
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0, 1);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1);
    settle_edge();
    applyStimulus(0, 0, 1, 1, 32'h0000_3040, 32'h0000_5003, 1);
    settle_edge();
    checkOutput("T4_jr_addr", imem_addr, 32'h0000_5000);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1);
    settle_edge();
    checkOutput("T4_jr_pc", PC_D, 32'h0000_5000);

    // Two-cycle decode stall while a fetch completes
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0, 1);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1);
    settle_edge();
    applyStimulus(0, 1, 0, 0, 32'd0, 32'd0, 1);
    settle_edge();
    checkOutput("T5_hold_pc", PC_D, 32'h0000_3000);
    checkOutput("T5_req_drop", imem_req, 32'd0);
    settle_edge();
    checkOutput("T5_hold_pc2", PC_D, 32'h0000_3000);
    checkOutput("T5_req_drop2", imem_req, 32'd0);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1);
    settle_edge();
    checkOutput("T5_release_pc", PC_D, 32'h0000_3004);
    checkOutput("T5_req_back", imem_req, 32'd1);
    checkOutput("T5_resume_addr", imem_addr, 32'h0000_3008);
    settle_edge();
    checkOutput("T5_next_pc", PC_D, 32'h0000_3008);

    // Reset during a wait with a redirect pending
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0, 1);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1);
    settle_edge();
    applyStimulus(0, 0, 1, 0, 32'h0000_3040, 32'd0, 0);
    settle_edge();
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0, 0);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 0);
    #1;
    checkOutput("T6_addr", imem_addr, 32'h0000_3000);
    checkOutput("T6_valid", valid_D, 32'd0);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1);
    settle_edge();
    checkOutput("T6_pc", PC_D, 32'h0000_3000);
    checkOutput("T6_no_redirect", imem_addr, 32'h0000_3004);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      r_rst   = ($urandom_range(0, 299) == 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_rdy   = ($urandom_range(0, 2) != 0);
      r_sel   = 1'($urandom_range(0, 1));
      r_npc   = RESET_PC + 32'($urandom_range(0, 1023) * 4) + 32'($urandom_range(0, 3));
      r_jr    = $urandom();
      r_rd    = (!ds_next && !ds_in) ? ($urandom_range(0, 3) == 0) : 1'b0;
      applyStimulus(r_rst, r_stall, r_rd, r_sel, r_npc, r_jr, r_rdy);
    end
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1);
    repeat (3) settle_edge();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
